sram_port_arbiter: RTL

- Shares one downstream SRAM-like port (req / addr_ok / data_ok) between the instruction-side and data-side SRAM-like requesters from the core.
- Sits between cpu_sram and sram_to_axi, so a single bridge channel serves both sides.
- Tracks outstanding transactions in order and steers each data_ok / rdata back to the requester that issued it.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_port_arbiter_if.sv | 36 +++
 rtl/sram_port_arbiter_owner_fifo.sv | 68 ++++++
 rtl/sram_port_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM-like port arbiter: command struct, owner tag, widths.
package sram_arb_pkg;

    localparam int SRAM_CMD_W = 72;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        uncached;
    } sram_cmd_t;

    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the I-side, D-side and downstream SRAM-like signals around the arbiter.
interface sram_port_arbiter_if;
    import sram_arb_pkg::*;

    // Handshake: a request is accepted in the cycle req & addr_ok (addr_ok is the ready);
    // cmd must stay stable while req is high and not yet accepted. data_ok is a one-cycle
    // response strobe, returned in acceptance order, with rdata valid in the same cycle.
    logic        i_req;
    sram_cmd_t   i_cmd;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;

    logic        d_req;
    sram_cmd_t   d_cmd;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    logic        m_req;
    sram_cmd_t   m_cmd;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    modport slave (
        input  i_req, i_cmd, d_req, d_cmd, m_addr_ok, m_data_ok, m_rdata,
        output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata, m_req, m_cmd
    );

    modport master (
        output i_req, i_cmd, d_req, d_cmd, m_addr_ok, m_data_ok, m_rdata,
        input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata, m_req, m_cmd
    );

endinterface

// File: rtl/sram_port_arbiter_owner_fifo.sv
// In-order owner tag FIFO: one bit per outstanding transaction (I or D), head drives routing.
module owner_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  owner_e                   push_owner,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output owner_e                   head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    owner_e          mem_q [DEPTH];
    owner_e          mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    // full/empty come from the registered count, so a pop never frees a slot in its own cycle
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_owner;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: OWN_I};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like downstream port between I and D requesters, steering responses in order.
// ARB_STARVE_GUARD_EN: forces an I grant after STARVE_LIMIT consecutive D accepts with I waiting.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
`ifdef ARB_STARVE_GUARD_EN
    , parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic               clk,
    input  logic               reset,
    sram_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    logic          lock_valid_q, lock_valid_d;
    owner_e        lock_owner_q, lock_owner_d;
    owner_e        grant, head;
    logic          m_req, accept, pop, full, empty, starve_force;
    logic [CW-1:0] count;
    logic [CW-1:0] orphan_q, orphan_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_owner_q <= OWN_I;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    // A pending, unaccepted request pins the grant so m_cmd cannot change under it
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        if (m_req && bus.m_addr_ok) begin
            lock_valid_d = 1'b0;
        end else if (m_req) begin
            lock_valid_d = 1'b1;
            lock_owner_d = grant;
        end
    end

    always_comb begin
        grant = OWN_D;
        if (lock_valid_q)      grant = lock_owner_q;
        else if (starve_force) grant = OWN_I;
        else if (bus.d_req)    grant = OWN_D;
        else if (bus.i_req)    grant = OWN_I;
        m_req         = (bus.i_req | bus.d_req) & ~full;
        accept        = m_req & bus.m_addr_ok;
        pop           = bus.m_data_ok & ~empty;
        bus.m_req     = m_req;
        bus.m_cmd     = (m_req && grant == OWN_I) ? bus.i_cmd : bus.d_cmd;
        bus.i_addr_ok = accept & (grant == OWN_I);
        bus.d_addr_ok = accept & (grant == OWN_D);
        bus.i_data_ok = pop & (head == OWN_I);
        bus.d_data_ok = pop & (head == OWN_D);
        bus.i_rdata   = bus.m_rdata;
        bus.d_rdata   = bus.m_rdata;
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_force = (starve_cnt_q == SW'(STARVE_LIMIT)) & bus.i_req;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (accept) begin
            if (grant == OWN_I || !bus.i_req) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) starve_cnt_q <= '0;
        else       starve_cnt_q <= starve_cnt_d;
    end
`else
    assign starve_force = 1'b0;
`endif

    owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_owner (grant),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head       (head),
        .count      (count)
    );

    // Responses still in flight when reset hit are legitimately dropped; only unexplained ones are flagged
    always_comb begin
        orphan_d = orphan_q;
        if (reset) begin
            orphan_d = count;
        end else if (bus.m_data_ok && empty && orphan_q != '0) begin
            orphan_d = orphan_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        orphan_q <= orphan_d;
        if (!reset) begin
            assert (!(bus.m_data_ok && empty) || orphan_q != '0);
        end
    end

endmodule
